// File: rtl/systolic_result_tx.sv
// Result return path: buffers bytes from the systolic array in a FIFO and
// serialises them to the host as UART 8N1, LSB first.
module systolic_result_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sys_enable,
    input  logic [7:0] cbit_out,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    state_t            state, state_d;
    logic [BAUD_W-1:0] baud_cnt, baud_d;
    logic [2:0]        bit_idx, bit_d;
    logic [7:0]        shift, shift_d;
    logic              tx_d, busy_d;

    logic pop, push, drop, baud_end;

    // A full FIFO still accepts a byte when the transmitter frees a slot in the same cycle.
    assign pop       = (state == IDLE) && (count != '0);
    assign push      = sys_enable && ((count != DEPTH) || pop);
    assign drop      = sys_enable && !push;
    assign fifo_full = (count == DEPTH);
    assign baud_end  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cbit_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        tx_d    = 1'b1;
        busy_d  = (state != IDLE);

        case (state)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[rd_ptr];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx and tx_busy lag the state register by one cycle so the line is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            tx       <= tx_d;
            tx_busy  <= busy_d;
        end
    end

endmodule
